vx_exec_splitter: RTL and testbench
===================================

Name: VX_exec_splitter

Overview:
Transmitting end of the execute interface. Accepts one full-warp dispatch operation (NUM_THREADS lanes of operands) and serializes it into NUM_LANES-wide beats on an execute interface master port. Each beat carries a partition id, start-of-packet and end-of-packet flags. Partitions whose thread-mask slice is all zero are skipped. Sits between the dispatch/operand-collect stage and each functional unit whose SIMD width is narrower than the warp.

Parameters:
NUM_THREADS, `NUM_THREADS, warp width in lanes; must be a multiple of NUM_LANES.
NUM_LANES, `SIMD_WIDTH, lanes per output beat.
PID_COUNT, NUM_THREADS/NUM_LANES, number of partitions (derived).
PID_WIDTH, `LOG2UP(PID_COUNT), partition id width (derived).

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
in_valid  in  1  input operation valid
in_ready  out  1  input accepted when in_valid && in_ready
in_uuid  in  UUID_WIDTH  instruction uuid
in_lid  in  VL_WIDTH  lane/local id, passed through
in_wid  in  NW_WIDTH  warp id
in_tmask  in  NUM_THREADS  thread mask
in_PC  in  PC_BITS  program counter
in_op_type  in  INST_ALU_BITS  op type
in_op_args  in  op_args_t  op arguments
in_wb  in  1  writeback enable
in_rd  in  NR_BITS  destination register
in_rs1_data / in_rs2_data / in_rs3_data  in  NUM_THREADS*XLEN each  operands, lane-major
execute_if  master  VX_execute_if #(NUM_LANES, PID_WIDTH)  outputs valid/data; ready is an input

Behaviour:
- One clock (clk), synchronous active-high reset. On reset: execute_if.valid=0, in_ready=1, state=IDLE, pid register=0, and all held data is discarded.
- Chunk mask: cmask[p] = |in_tmask[p*NUM_LANES +: NUM_LANES]. It is computed on capture and registered.
- States:
  - IDLE: in_ready=1, valid=0. On an input handshake, register all fields, set pid to the first set bit of cmask, set first=1, and go to SEND.
  - SEND: valid=1. Beat fields:
    - uuid/lid/wid/PC/op_type/op_args/wb/rd come from the held copy.
    - tmask and rsN_data are the pid slice.
    - pid = current partition.
    - sop = first.
    - eop = no set cmask bit above pid.
  - On a beat handshake with eop=0: pid advances to the next set cmask bit above the current one (skipping zero chunks), and first clears.
  - On a beat handshake with eop=1: go to IDLE.
- Back-to-back: in SEND, in_ready = execute_if.ready && eop. An input handshake in the same cycle as the eop beat handshake captures the new op and stays in SEND. The first beat of the new op is valid on the next cycle, with no bubble.
- Latency: input handshake at cycle N gives the first beat valid at N+1. An op with k non-empty chunks occupies k output handshakes.
- All-zero in_tmask: emit exactly one beat with pid=0, sop=eop=1, tmask=0.
- PID_COUNT=1: every op is a single beat with pid=0, sop=eop=1. The registered one-cycle latency still applies.
- Backpressure: while valid && !ready, every execute_if.data field is held stable and valid is not dropped.
- Reset mid-operation: remaining beats are dropped; no partial eop is emitted.
- Data registers need no reset; only the control state is reset.

Decomposition:
- Shared package VX_gpu_pkg: UUID_WIDTH, VL_WIDTH, NW_WIDTH, PC_BITS, INST_ALU_BITS, NR_BITS, op_args_t (existing); add a localparam function for PID_COUNT.
- One sub-module, VX_chunk_scan. Inputs: cmask[PID_COUNT] and cur_pid. Outputs: next_pid (first set bit strictly above cur_pid) and has_next. The same sub-module in "from -1" mode gives the first pid at capture. It is purely combinational, with a priority encoder over the masked vector.

Test Plan:
1. NUM_THREADS=8, NUM_LANES=2, tmask=0xFF, ready=1 -> 4 beats pid 0,1,2,3. sop only on pid0, eop only on pid3. Each beat tmask=2'b11 and rs1_data = lanes {2p+1,2p}.
2. tmask=0x30 -> single beat pid=2, tmask=2'b11, sop=eop=1. in_ready returns to 1 the cycle after.
3. tmask=0x81 -> two beats: pid0 with tmask=2'b01 and sop=1, then pid3 with tmask=2'b10 and eop=1. No pid1/pid2 beats.
4. tmask=0xFF with ready held low for 3 cycles at pid1 -> valid=1 and data identical for all 3 cycles. pid2 follows the cycle after ready rises. in_ready stays 0 throughout.
5. Two ops (tmask 0x0C, then 0xFF) offered back-to-back -> op B is accepted in the same cycle as op A's eop beat. Op B pid0 is valid on the next cycle with no idle cycle.
6. Reset asserted during SEND at pid1 -> next cycle valid=0, in_ready=1. A new op accepted after reset starts at its first pid with sop=1.

Source files
------------

// File: rtl/vx_exec_splitter_pkg.sv
// Shared widths and types for the execute-splitter slice: instruction field
// widths, operand argument struct, splitter FSM states and partition helpers.
package vx_exec_splitter_pkg;

  localparam int UUID_WIDTH    = 16;
  localparam int VL_WIDTH      = 2;
  localparam int NW_WIDTH      = 2;
  localparam int PC_BITS       = 32;
  localparam int INST_ALU_BITS = 4;
  localparam int NR_BITS       = 6;
  localparam int XLEN          = 32;

  typedef struct packed {
    logic        use_pc;
    logic        use_imm;
    logic [19:0] imm;
  } op_args_t;

  localparam int OP_ARGS_BITS = $bits(op_args_t);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } split_state_e;

  function automatic int pid_count(input int num_threads, input int num_lanes);
    return num_threads / num_lanes;
  endfunction

  // Width of an index over n items, never narrower than one bit.
  function automatic int log2up(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vx_exec_splitter_chunk_scan.sv
// Finds the lowest set chunk-mask bit strictly above cur_pid, or the lowest set
// bit overall when from_start is high. Purely combinational.
module vx_exec_splitter_chunk_scan #(
  parameter int PID_COUNT = 4,
  parameter int PID_WIDTH = 2
) (
  input  logic [PID_COUNT-1:0] cmask,
  input  logic [PID_WIDTH-1:0] cur_pid,
  input  logic                 from_start,
  output logic [PID_WIDTH-1:0] next_pid,
  output logic                 has_next
);

  // Walk from the top down so the lowest qualifying bit is the last one written.
  always_comb begin
    next_pid = '0;
    has_next = 1'b0;
    for (int p = PID_COUNT - 1; p >= 0; p--) begin
      if (cmask[p] && (from_start || (PID_WIDTH'(p) > cur_pid))) begin
        next_pid = PID_WIDTH'(p);
        has_next = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vx_exec_splitter.sv
// Serializes one full-warp operation into NUM_LANES-wide execute beats,
// skipping partitions whose thread-mask slice is empty.
module vx_exec_splitter
  import vx_exec_splitter_pkg::*;
#(
  parameter  int NUM_THREADS = 8,
  parameter  int NUM_LANES   = 2,
  localparam int PID_COUNT   = pid_count(NUM_THREADS, NUM_LANES),
  localparam int PID_WIDTH   = log2up(PID_COUNT)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [UUID_WIDTH-1:0]          in_uuid,
  input  logic [VL_WIDTH-1:0]            in_lid,
  input  logic [NW_WIDTH-1:0]            in_wid,
  input  logic [NUM_THREADS-1:0]         in_tmask,
  input  logic [PC_BITS-1:0]             in_PC,
  input  logic [INST_ALU_BITS-1:0]       in_op_type,
  input  logic [OP_ARGS_BITS-1:0]        in_op_args,
  input  logic                           in_wb,
  input  logic [NR_BITS-1:0]             in_rd,
  input  logic [NUM_THREADS*XLEN-1:0]    in_rs1_data,
  input  logic [NUM_THREADS*XLEN-1:0]    in_rs2_data,
  input  logic [NUM_THREADS*XLEN-1:0]    in_rs3_data,
  output logic                           execute_if_valid,
  input  logic                           execute_if_ready,
  output logic [UUID_WIDTH-1:0]          execute_if_uuid,
  output logic [VL_WIDTH-1:0]            execute_if_lid,
  output logic [NW_WIDTH-1:0]            execute_if_wid,
  output logic [NUM_LANES-1:0]           execute_if_tmask,
  output logic [PC_BITS-1:0]             execute_if_PC,
  output logic [INST_ALU_BITS-1:0]       execute_if_op_type,
  output logic [OP_ARGS_BITS-1:0]        execute_if_op_args,
  output logic                           execute_if_wb,
  output logic [NR_BITS-1:0]             execute_if_rd,
  output logic [NUM_LANES*XLEN-1:0]      execute_if_rs1_data,
  output logic [NUM_LANES*XLEN-1:0]      execute_if_rs2_data,
  output logic [NUM_LANES*XLEN-1:0]      execute_if_rs3_data,
  output logic [PID_WIDTH-1:0]           execute_if_pid,
  output logic                           execute_if_sop,
  output logic                           execute_if_eop,
  output logic                           dbg_state
);

  split_state_e           state, state_n;
  logic [PID_WIDTH-1:0]   pid, pid_n;
  logic                   first, first_n;
  logic [PID_COUNT-1:0]   in_cmask, cmask_q;
  logic [PID_WIDTH-1:0]   first_pid, next_pid;
  logic                   first_found, has_next;
  logic                   in_fire, beat_fire;

  logic [UUID_WIDTH-1:0]       uuid_q;
  logic [VL_WIDTH-1:0]         lid_q;
  logic [NW_WIDTH-1:0]         wid_q;
  logic [NUM_THREADS-1:0]      tmask_q;
  logic [PC_BITS-1:0]          pc_q;
  logic [INST_ALU_BITS-1:0]    op_type_q;
  logic [OP_ARGS_BITS-1:0]     op_args_q;
  logic                        wb_q;
  logic [NR_BITS-1:0]          rd_q;
  logic [NUM_THREADS*XLEN-1:0] rs1_q, rs2_q, rs3_q;

  always_comb begin
    in_cmask = '0;
    for (int p = 0; p < PID_COUNT; p++) begin
      in_cmask[p] = |in_tmask[p*NUM_LANES +: NUM_LANES];
    end
  end

  vx_exec_splitter_chunk_scan #(.PID_COUNT(PID_COUNT), .PID_WIDTH(PID_WIDTH)) u_first_scan (
    .cmask      (in_cmask),
    .cur_pid    ('0),
    .from_start (1'b1),
    .next_pid   (first_pid),
    .has_next   (first_found)
  );

  vx_exec_splitter_chunk_scan #(.PID_COUNT(PID_COUNT), .PID_WIDTH(PID_WIDTH)) u_next_scan (
    .cmask      (cmask_q),
    .cur_pid    (pid),
    .from_start (1'b0),
    .next_pid   (next_pid),
    .has_next   (has_next)
  );

  // An all-zero mask finds nothing and falls back to pid 0 as a single beat.
  assign execute_if_eop = !has_next;
  assign beat_fire      = execute_if_valid && execute_if_ready;
  assign in_fire        = in_valid && in_ready;

  always_comb begin
    state_n          = state;
    pid_n            = pid;
    first_n          = first;
    in_ready         = 1'b0;
    execute_if_valid = 1'b0;
    case (state)
      ST_IDLE: in_ready = 1'b1;
      ST_SEND: begin
        execute_if_valid = 1'b1;
        in_ready         = execute_if_ready && execute_if_eop;
        if (beat_fire) begin
          if (execute_if_eop) begin
            state_n = ST_IDLE;
          end else begin
            pid_n   = next_pid;
            first_n = 1'b0;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase
    // A capture overrides the eop return to IDLE, giving bubble-free back-to-back ops.
    if (in_fire) begin
      state_n = ST_SEND;
      pid_n   = first_found ? first_pid : '0;
      first_n = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      pid   <= '0;
      first <= 1'b0;
    end else begin
      state <= state_n;
      pid   <= pid_n;
      first <= first_n;
    end
  end

  always_ff @(posedge clk) begin
    if (in_fire) begin
      cmask_q   <= in_cmask;
      uuid_q    <= in_uuid;
      lid_q     <= in_lid;
      wid_q     <= in_wid;
      tmask_q   <= in_tmask;
      pc_q      <= in_PC;
      op_type_q <= in_op_type;
      op_args_q <= in_op_args;
      wb_q      <= in_wb;
      rd_q      <= in_rd;
      rs1_q     <= in_rs1_data;
      rs2_q     <= in_rs2_data;
      rs3_q     <= in_rs3_data;
    end
  end

  always_comb begin
    execute_if_tmask    = '0;
    execute_if_rs1_data = '0;
    execute_if_rs2_data = '0;
    execute_if_rs3_data = '0;
    for (int p = 0; p < PID_COUNT; p++) begin
      if (pid == PID_WIDTH'(p)) begin
        execute_if_tmask    = tmask_q[p*NUM_LANES +: NUM_LANES];
        execute_if_rs1_data = rs1_q[p*NUM_LANES*XLEN +: NUM_LANES*XLEN];
        execute_if_rs2_data = rs2_q[p*NUM_LANES*XLEN +: NUM_LANES*XLEN];
        execute_if_rs3_data = rs3_q[p*NUM_LANES*XLEN +: NUM_LANES*XLEN];
      end
    end
  end

  assign execute_if_uuid    = uuid_q;
  assign execute_if_lid     = lid_q;
  assign execute_if_wid     = wid_q;
  assign execute_if_PC      = pc_q;
  assign execute_if_op_type = op_type_q;
  assign execute_if_op_args = op_args_q;
  assign execute_if_wb      = wb_q;
  assign execute_if_rd      = rd_q;
  assign execute_if_pid     = pid;
  assign execute_if_sop     = first;
  assign dbg_state          = state;

endmodule

// File: tb/tb_vx_exec_splitter.sv
// Bench for vx_exec_splitter: directed scenarios plus randomized ops and
// backpressure, checked against a per-op beat-list reference model.
module tb_vx_exec_splitter;
  import vx_exec_splitter_pkg::*;

  localparam int NT = 8;
  localparam int NL = 2;
  localparam int PC = NT / NL;
  localparam int PW = 2;
  localparam int BW = UUID_WIDTH + VL_WIDTH + NW_WIDTH + PC_BITS + INST_ALU_BITS +
                      OP_ARGS_BITS + 1 + NR_BITS + PW + 2 + NL + 3*NL*XLEN;
  typedef logic [BW-1:0] beat_t;

  logic                     clk = 1'b0;
  logic                     reset;
  logic                     in_valid;
  logic                     in_ready;
  logic [UUID_WIDTH-1:0]    in_uuid;
  logic [VL_WIDTH-1:0]      in_lid;
  logic [NW_WIDTH-1:0]      in_wid;
  logic [NT-1:0]            in_tmask;
  logic [PC_BITS-1:0]       in_PC;
  logic [INST_ALU_BITS-1:0] in_op_type;
  logic [OP_ARGS_BITS-1:0]  in_op_args;
  logic                     in_wb;
  logic [NR_BITS-1:0]       in_rd;
  logic [NT*XLEN-1:0]       in_rs1_data, in_rs2_data, in_rs3_data;
  logic                     execute_if_valid;
  logic                     execute_if_ready;
  logic [UUID_WIDTH-1:0]    execute_if_uuid;
  logic [VL_WIDTH-1:0]      execute_if_lid;
  logic [NW_WIDTH-1:0]      execute_if_wid;
  logic [NL-1:0]            execute_if_tmask;
  logic [PC_BITS-1:0]       execute_if_PC;
  logic [INST_ALU_BITS-1:0] execute_if_op_type;
  logic [OP_ARGS_BITS-1:0]  execute_if_op_args;
  logic                     execute_if_wb;
  logic [NR_BITS-1:0]       execute_if_rd;
  logic [NL*XLEN-1:0]       execute_if_rs1_data, execute_if_rs2_data, execute_if_rs3_data;
  logic [PW-1:0]            execute_if_pid;
  logic                     execute_if_sop;
  logic                     execute_if_eop;
  logic                     dbg_state;

  vx_exec_splitter #(.NUM_THREADS(NT), .NUM_LANES(NL)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_uuid(in_uuid), .in_lid(in_lid), .in_wid(in_wid), .in_tmask(in_tmask),
    .in_PC(in_PC), .in_op_type(in_op_type), .in_op_args(in_op_args),
    .in_wb(in_wb), .in_rd(in_rd),
    .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data), .in_rs3_data(in_rs3_data),
    .execute_if_valid(execute_if_valid), .execute_if_ready(execute_if_ready),
    .execute_if_uuid(execute_if_uuid), .execute_if_lid(execute_if_lid),
    .execute_if_wid(execute_if_wid), .execute_if_tmask(execute_if_tmask),
    .execute_if_PC(execute_if_PC), .execute_if_op_type(execute_if_op_type),
    .execute_if_op_args(execute_if_op_args), .execute_if_wb(execute_if_wb),
    .execute_if_rd(execute_if_rd),
    .execute_if_rs1_data(execute_if_rs1_data), .execute_if_rs2_data(execute_if_rs2_data),
    .execute_if_rs3_data(execute_if_rs3_data),
    .execute_if_pid(execute_if_pid), .execute_if_sop(execute_if_sop),
    .execute_if_eop(execute_if_eop), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  int    n_checks = 0;
  int    n_pass   = 0;
  beat_t exp_q[$];

  task automatic check(input string tag, input beat_t got, input beat_t exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  function automatic beat_t pack_beat(
    input logic [UUID_WIDTH-1:0] uuid, input logic [VL_WIDTH-1:0] lid,
    input logic [NW_WIDTH-1:0] wid, input logic [PC_BITS-1:0] pc,
    input logic [INST_ALU_BITS-1:0] op, input logic [OP_ARGS_BITS-1:0] args,
    input logic wb, input logic [NR_BITS-1:0] rd, input logic [PW-1:0] pid,
    input logic sop, input logic eop, input logic [NL-1:0] tm,
    input logic [NL*XLEN-1:0] r1, input logic [NL*XLEN-1:0] r2, input logic [NL*XLEN-1:0] r3);
    return {uuid, lid, wid, pc, op, args, wb, rd, pid, sop, eop, tm, r1, r2, r3};
  endfunction

  // Reference: an op becomes one beat per non-empty lane group in ascending
  // order, or a single empty pid-0 beat when no thread is active.
  function automatic void model_push();
    int pids[$];
    for (int p = 0; p < PC; p++)
      if (in_tmask[p*NL +: NL] != '0) pids.push_back(p);
    if (pids.size() == 0) pids.push_back(0);
    for (int i = 0; i < pids.size(); i++) begin
      int p = pids[i];
      exp_q.push_back(pack_beat(in_uuid, in_lid, in_wid, in_PC, in_op_type, in_op_args,
        in_wb, in_rd, PW'(p), i == 0, i == pids.size() - 1, in_tmask[p*NL +: NL],
        in_rs1_data[p*NL*XLEN +: NL*XLEN], in_rs2_data[p*NL*XLEN +: NL*XLEN],
        in_rs3_data[p*NL*XLEN +: NL*XLEN]));
    end
  endfunction

  // Monitor: compares every handshaken beat, and checks that a stalled beat
  // is held unchanged with valid still asserted on the following cycle.
  logic  stall_seen = 1'b0;
  beat_t stall_beat;
  beat_t obs;
  always @(negedge clk) begin
    obs = pack_beat(execute_if_uuid, execute_if_lid, execute_if_wid, execute_if_PC,
      execute_if_op_type, execute_if_op_args, execute_if_wb, execute_if_rd,
      execute_if_pid, execute_if_sop, execute_if_eop, execute_if_tmask,
      execute_if_rs1_data, execute_if_rs2_data, execute_if_rs3_data);
    if (reset) begin
      stall_seen = 1'b0;
    end else begin
      if (stall_seen) begin
        check("stall_valid", execute_if_valid, 1);
        check("stall_hold", obs, stall_beat);
      end
      if (execute_if_valid && execute_if_ready) begin
        if (exp_q.size() == 0) check("extra_beat", 1, 0);
        else check("beat", obs, exp_q.pop_front());
      end
      stall_seen = execute_if_valid && !execute_if_ready;
      stall_beat = obs;
    end
  end

  // ---------------- drivers ----------------
  int ready_mode = 0;  // 0: ready high, 1: ready low, 2: random
  always @(posedge clk) begin
    #2;
    case (ready_mode)
      0:       execute_if_ready = 1'b1;
      1:       execute_if_ready = 1'b0;
      default: execute_if_ready = ($urandom_range(0, 3) != 0);
    endcase
  end

  task automatic send_op(input logic [NT-1:0] tm, output int waited);
    logic acc = 1'b0;
    in_uuid    = UUID_WIDTH'($urandom);
    in_lid     = VL_WIDTH'($urandom);
    in_wid     = NW_WIDTH'($urandom);
    in_PC      = $urandom;
    in_op_type = INST_ALU_BITS'($urandom);
    in_op_args = OP_ARGS_BITS'($urandom);
    in_wb      = 1'($urandom);
    in_rd      = NR_BITS'($urandom);
    for (int w = 0; w < NT; w++) begin
      in_rs1_data[w*XLEN +: XLEN] = $urandom;
      in_rs2_data[w*XLEN +: XLEN] = $urandom;
      in_rs3_data[w*XLEN +: XLEN] = $urandom;
    end
    in_tmask = tm;
    in_valid = 1'b1;
    waited   = 0;
    for (int c = 0; c <= 200 && !acc; c++) begin
      @(negedge clk);
      if (in_ready) acc = 1'b1;
      else begin
        waited++;
        @(posedge clk); #1;
      end
    end
    if (!acc) begin
      check("accept_timeout", 0, 1);
      in_valid = 1'b0;
    end else begin
      model_push();
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    for (int c = 0; c < 500 && exp_q.size() != 0; c++) begin
      @(posedge clk); #1;
    end
    check("drain_empty", exp_q.size(), 0);
    ready_mode = 0;
    @(posedge clk); #1;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // ---------------- test sequence ----------------
  int w;
  initial begin
    reset = 1'b1; in_valid = 1'b0; in_tmask = '0; execute_if_ready = 1'b1;
    in_uuid = '0; in_lid = '0; in_wid = '0; in_PC = '0; in_op_type = '0;
    in_op_args = '0; in_wb = 1'b0; in_rd = '0;
    in_rs1_data = '0; in_rs2_data = '0; in_rs3_data = '0;
    repeat (3) tick();
    reset = 1'b0;
    @(negedge clk);
    check("rst_valid", execute_if_valid, 0);
    check("rst_in_ready", in_ready, 1);
    tick();

    // Full mask: four beats pid 0..3
    send_op(8'hFF, w);
    @(negedge clk);
    check("t1_first_valid", execute_if_valid, 1);
    check("t1_first_sop", execute_if_sop, 1);
    drain();

    // Single middle chunk, then idle again
    send_op(8'h30, w);
    @(negedge clk);
    check("t2_pid", execute_if_pid, 2);
    check("t2_sop_eop", {execute_if_sop, execute_if_eop}, 2'b11);
    tick();
    @(negedge clk);
    check("t2_idle_valid", execute_if_valid, 0);
    check("t2_idle_ready", in_ready, 1);
    drain();

    // Sparse mask skipping pid1/pid2, and all-zero mask
    send_op(8'h81, w);
    drain();
    send_op(8'h00, w);
    @(negedge clk);
    check("zero_tmask", execute_if_tmask, 0);
    drain();

    // Stall three cycles at pid1
    send_op(8'hFF, w);
    tick();
    ready_mode = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t4_valid", execute_if_valid, 1);
      check("t4_pid", execute_if_pid, 1);
      check("t4_in_ready", in_ready, 0);
      tick();
    end
    ready_mode = 0;
    drain();

    // Back-to-back ops: B accepted on A's eop beat, no bubble
    send_op(8'h0C, w);
    send_op(8'hFF, w);
    check("t5_b2b_wait", w, 0);
    @(negedge clk);
    check("t5_b_valid", execute_if_valid, 1);
    check("t5_b_pid_sop", {execute_if_pid, execute_if_sop}, {2'd0, 1'b1});
    drain();

    // Reset in the middle of an op
    send_op(8'hFF, w);
    tick();
    ready_mode = 1;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_q.delete();
    ready_mode = 0;
    @(negedge clk);
    check("t6_valid", execute_if_valid, 0);
    check("t6_in_ready", in_ready, 1);
    tick();
    send_op(8'h0C, w);
    @(negedge clk);
    check("t6_new_pid_sop", {execute_if_pid, execute_if_sop}, {2'd1, 1'b1});
    drain();

    // Randomized ops under random backpressure
    ready_mode = 2;
    for (int n = 0; n < 80; n++) begin
      logic [NT-1:0] tm;
      case ($urandom_range(0, 3))
        0:       tm = '0;
        1:       tm = NT'(1) << $urandom_range(0, NT - 1);
        default: tm = NT'($urandom);
      endcase
      send_op(tm, w);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) tick();
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
